block_drawer: RTL and testbench

- Responder end of the controller's draw_start/draw_done shape handshake; one instance per on-screen block/obstacle.
- On each draw grant it erases its square at the old position and steps left if a screen update is pending.
- It then repaints the square at the new position and holds draw_done until the controller withdraws draw_start.
- Reports shape_gone once the block has scrolled off the left edge; the controller sums these for the score.

---
 rtl/shape_pkg.sv | 18 +
 rtl/pixel_scanner.sv | 30 +++
 rtl/block_drawer.sv | 117 +++++++++++
 tb/tb_block_drawer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/shape_pkg.sv
// Shared widths, colours and FSM encoding for the on-screen shape drawers.
package shape_pkg;

  localparam int COORD_W  = 11;
  localparam int COLOUR_W = 3;

  localparam logic [COLOUR_W-1:0] BLACK = 3'b000;
  localparam logic [COLOUR_W-1:0] WHITE = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    ERASE,
    MOVE,
    DRAW,
    DONE
  } state_t;

endpackage

// File: rtl/pixel_scanner.sv
// Row-major row/col scanner over a SIZE x SIZE square; last flags the bottom-right pixel.
module pixel_scanner #(
  parameter int SIZE  = 4,
  parameter int CNT_W = $clog2(SIZE)
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] row,
  output logic [CNT_W-1:0] col,
  output logic             last
);

  localparam logic [CNT_W-1:0] MAX = CNT_W'(SIZE - 1);

  // SIZE is a power of two, so both counters wrap back to zero on their own.
  always_ff @(posedge clock) begin
    if (!resetn || clear) begin
      row <= '0;
      col <= '0;
    end else if (enable) begin
      col <= col + 1'b1;
      if (col == MAX) row <= row + 1'b1;
    end
  end

  assign last = (row == MAX) && (col == MAX);

endmodule

// File: rtl/block_drawer.sv
// One scrolling block: erases itself, optionally steps left, redraws, then completes the
// 4-phase draw_start/draw_done handshake. Reports shape_gone once it has left the screen.
module block_drawer
  import shape_pkg::*;
#(
  parameter int                   SIZE    = 4,
  parameter int                   START_X = 160,
  parameter int                   START_Y = 100,
  parameter int                   STEP    = 1,
  parameter logic [COLOUR_W-1:0]  COLOUR  = 3'b111,
  parameter int                   X_MIN   = 0
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                draw_start,
  input  logic                update_screen,
  output logic                draw_done,
  output logic [COORD_W-1:0]  send_x,
  output logic [COORD_W-1:0]  send_y,
  output logic [COLOUR_W-1:0] send_colour,
  output logic                plot,
  output logic [COORD_W-1:0]  shape_gone
);

  localparam int CNT_W = $clog2(SIZE);
  localparam logic [COORD_W-1:0] X_RESET = COORD_W'(START_X);
  localparam logic [COORD_W-1:0] POS_Y   = COORD_W'(START_Y);
  localparam logic [COORD_W-1:0] STEP_C  = COORD_W'(STEP);
  localparam logic [COORD_W-1:0] X_GONE  = COORD_W'(X_MIN + STEP);

  state_t             state;
  logic [COORD_W-1:0] pos_x;
  logic               move_pending;
  logic               gone;

  logic               scan_en;
  logic [CNT_W-1:0]   row;
  logic [CNT_W-1:0]   col;
  logic               scan_last;

  assign scan_en = (state == ERASE) || (state == DRAW);

  pixel_scanner #(
    .SIZE  (SIZE),
    .CNT_W (CNT_W)
  ) u_scanner (
    .clock  (clock),
    .resetn (resetn),
    .clear  (!scan_en),
    .enable (scan_en),
    .row    (row),
    .col    (col),
    .last   (scan_last)
  );

  assign shape_gone = {{(COORD_W-1){1'b0}}, gone};

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state        <= IDLE;
      pos_x        <= X_RESET;
      move_pending <= 1'b0;
      gone         <= 1'b0;
      draw_done    <= 1'b0;
      plot         <= 1'b0;
      send_colour  <= BLACK;
      send_x       <= X_RESET;
      send_y       <= POS_Y;
    end else begin
      // NOTE: non-blocking assignments only; the defaults below are overridden by the
      // case arms, and every arm reads pre-edge values of pos_x and move_pending.
      plot        <= 1'b0;
      draw_done   <= 1'b0;
      send_colour <= BLACK;

      // A tick arriving in MOVE itself wins over the clear and carries to the next grant.
      if (update_screen)      move_pending <= 1'b1;
      else if (state == MOVE) move_pending <= 1'b0;

      case (state)
        IDLE: begin
          if (draw_start) state <= gone ? DONE : ERASE;
        end
        ERASE: begin
          plot   <= 1'b1;
          send_x <= pos_x + COORD_W'(col);
          send_y <= POS_Y + COORD_W'(row);
          if (scan_last) state <= MOVE;
        end
        MOVE: begin
          if (move_pending && (pos_x > X_GONE)) begin
            pos_x <= pos_x - STEP_C;
            state <= DRAW;
          end else if (move_pending) begin
            gone  <= 1'b1;
            state <= DONE;
          end else begin
            state <= DRAW;
          end
        end
        DRAW: begin
          plot        <= 1'b1;
          send_colour <= COLOUR;
          send_x      <= pos_x + COORD_W'(col);
          send_y      <= POS_Y + COORD_W'(row);
          if (scan_last) state <= DONE;
        end
        DONE: begin
          draw_done <= 1'b1;
          if (!draw_start) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_block_drawer.sv
// Scoreboard bench for block_drawer: a position/pending/gone model predicts every pixel
// (with its edge) and the draw_done timing; a monitor pops and compares each plotted pixel.
module tb_block_drawer;

  localparam int SIZE    = 4;
  localparam int START_X = 160;
  localparam int START_Y = 100;
  localparam int STEP    = 1;
  localparam int X_MIN   = 0;
  localparam int COLOUR  = 7;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        draw_start = 1'b0;
  logic        update_screen = 1'b0;
  logic        draw_done;
  logic [10:0] send_x;
  logic [10:0] send_y;
  logic [2:0]  send_colour;
  logic        plot;
  logic [10:0] shape_gone;

  block_drawer #(
    .SIZE    (SIZE),
    .START_X (START_X),
    .START_Y (START_Y),
    .STEP    (STEP),
    .COLOUR  (3'b111),
    .X_MIN   (X_MIN)
  ) dut (
    .clock         (clock),
    .resetn        (resetn),
    .draw_start    (draw_start),
    .update_screen (update_screen),
    .draw_done     (draw_done),
    .send_x        (send_x),
    .send_y        (send_y),
    .send_colour   (send_colour),
    .plot          (plot),
    .shape_gone    (shape_gone)
  );

  always #5 clock = ~clock;

  int cycle = 0;
  always @(posedge clock) cycle <= cycle + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  typedef struct {
    int x;
    int y;
    int c;
    int e;
  } pix_t;

  pix_t exp_q[$];

  // Reference model of the block, in screen terms.
  int m_pos_x   = START_X;
  bit m_pending = 1'b0;
  bit m_gone    = 1'b0;

  task automatic push_square(input int x0, input int colour, input int first_edge);
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++) begin
        pix_t p;
        p.x = x0 + c;
        p.y = START_Y + r;
        p.c = colour;
        p.e = first_edge + r * SIZE + c;
        exp_q.push_back(p);
      end
  endtask

  // Applies one grant to the model; returns the edge after which draw_done first shows.
  task automatic model_grant(input int g, input bit upd_in_move, output int exp_done);
    if (m_gone) begin
      exp_done = g + 1;
    end else begin
      push_square(m_pos_x, 0, g + 1);
      if (m_pending) begin
        if (m_pos_x > X_MIN + STEP) m_pos_x -= STEP;
        else m_gone = 1'b1;
      end
      m_pending = upd_in_move;
      if (m_gone) begin
        exp_done = g + 2 + SIZE * SIZE;
      end else begin
        push_square(m_pos_x, COLOUR, g + 2 + SIZE * SIZE);
        exp_done = g + 2 + 2 * SIZE * SIZE;
      end
    end
  endtask

  // Monitor: every plotted pixel must match the head of the scoreboard, on its edge.
  always @(posedge clock) begin
    pix_t e;
    #1;
    if (plot) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_pixel: got x=%0d y=%0d c=%0d expected no pixel (cycle %0d)",
                 send_x, send_y, send_colour, cycle);
      end else begin
        e = exp_q.pop_front();
        check("pixel_x", int'(send_x), e.x);
        check("pixel_y", int'(send_y), e.y);
        check("pixel_colour", int'(send_colour), e.c);
        check("pixel_edge", cycle, e.e);
      end
    end else begin
      check("idle_colour", int'(send_colour), 0);
      if (exp_q.size() > 0 && exp_q[0].e <= cycle) begin
        e = exp_q.pop_front();
        n_checks++;
        n_errors++;
        $display("FAIL missing_pixel: got plot=0 expected pixel x=%0d y=%0d at edge %0d (cycle %0d)",
                 e.x, e.y, e.e, cycle);
      end
    end
  end

  task automatic pulse_updates(input int n);
    repeat (n) begin
      @(negedge clock);
      update_screen = 1'b1;
      @(negedge clock);
      update_screen = 1'b0;
    end
    if (n > 0) m_pending = 1'b1;
  endtask

  // One full handshake. drop_off > 0 withdraws draw_start before edge g+drop_off.
  task automatic do_grant(input bit upd_in_move, input int drop_off);
    int  g, exp_done, seen, drop_edge;
    bit  upd, dropped;
    @(negedge clock);
    draw_start = 1'b1;
    g = cycle + 1;
    upd = upd_in_move && !m_gone;
    drop_edge = (drop_off > 0 && !m_gone) ? g + drop_off : -1;
    model_grant(g, upd, exp_done);
    dropped = 1'b0;
    seen = -1;
    for (int i = 0; i < 60 && seen < 0; i++) begin
      if (i > 0) @(negedge clock);
      update_screen = upd && (cycle + 1 == g + 1 + SIZE * SIZE);
      if (cycle + 1 == drop_edge) begin
        draw_start = 1'b0;
        dropped = 1'b1;
      end
      @(posedge clock);
      #1;
      if (draw_done) seen = cycle;
    end
    update_screen = 1'b0;
    check("done_edge", seen, exp_done);
    if (!dropped) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clock);
        #1;
        check("done_held", int'(draw_done), 1);
      end
      @(negedge clock);
      draw_start = 1'b0;
      @(posedge clock);
      #1;
      check("done_last", int'(draw_done), 1);
    end
    draw_start = 1'b0;
    @(posedge clock);
    #1;
    check("done_release", int'(draw_done), 0);
    check("shape_gone", int'(shape_gone), int'(m_gone));
  endtask

  task automatic check_reset_state();
    check("rst_plot", int'(plot), 0);
    check("rst_draw_done", int'(draw_done), 0);
    check("rst_send_x", int'(send_x), START_X);
    check("rst_send_y", int'(send_y), START_Y);
    check("rst_colour", int'(send_colour), 0);
    check("rst_shape_gone", int'(shape_gone), 0);
  endtask

  // Reset lands on the edge that would have produced draw pixel 5.
  task automatic reset_mid_draw();
    int g, exp_done, rst_edge;
    @(negedge clock);
    draw_start = 1'b1;
    g = cycle + 1;
    model_grant(g, 1'b0, exp_done);
    rst_edge = g + 2 + SIZE * SIZE + 5;
    while (cycle + 1 < rst_edge) @(negedge clock);
    while (exp_q.size() > 0 && exp_q[$].e >= rst_edge) void'(exp_q.pop_back());
    resetn = 1'b0;
    draw_start = 1'b0;
    @(posedge clock);
    #1;
    check_reset_state();
    m_pos_x = START_X;
    m_pending = 1'b0;
    m_gone = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
  endtask

  initial begin
    int iter, post_gone;
    repeat (2) @(posedge clock);
    #1;
    check_reset_state();
    @(negedge clock);
    resetn = 1'b1;

    do_grant(1'b0, 0);          // no update: erase and redraw at 160
    pulse_updates(1);
    do_grant(1'b0, 0);          // 160 -> 159
    pulse_updates(3);
    do_grant(1'b0, 0);          // ticks collapse: 159 -> 158
    pulse_updates(1);
    do_grant(1'b1, 0);          // tick in MOVE keeps pending set
    do_grant(1'b0, 0);          // moves again with no new tick
    do_grant(1'b0, 4);          // draw_start withdrawn at erase pixel 3
    pulse_updates(1);
    reset_mid_draw();
    do_grant(1'b0, 0);          // back at START_X after reset

    // Random scroll until the block leaves the screen, then a few grants more.
    iter = 0;
    post_gone = 0;
    while (iter < 400 && post_gone < 3) begin
      pulse_updates(($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 3));
      repeat ($urandom_range(0, 2)) @(negedge clock);
      do_grant($urandom_range(0, 3) == 0,
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 17)) : 0);
      if (m_gone) post_gone++;
      iter++;
    end
    check("reached_gone", int'(m_gone), 1);

    repeat (5) @(posedge clock);
    #2;
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cycle);
    $fatal(1, "watchdog");
  end

endmodule
